// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings (common with uart_rx) and
// bit-timing / parity helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } uart_state_e;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: registered one-cycle tick during the last clock of each
// bit period; clear holds the counter at zero.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic        tick_q;
    logic        tick_d;

    // Next count: wrap at the end of each bit period.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = 16'd0;
        end else if (cnt_q == LAST) begin
            cnt_d = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
        tick_d = !clear && (cnt_d == LAST);
    end

    // Counter and tick registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= 16'd0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1; define UART_TX_PARITY_EN for an extra even-parity bit.
// One byte per valid/ready handshake, all outputs registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int baud     = 115200,
    parameter int CLK_FREQ = 100_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_data_valid,
    input  logic [7:0] i_data_byte,
    output logic       o_ready,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, baud);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
        $fatal(1, "uart_tx: CLKS_PER_BIT out of range 2..65535");
    end

    uart_state_e state_q, state_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        accept_s;
    logic        clear_s;
    logic        tick_s;

    assign accept_s = i_data_valid && ready_q;
    assign clear_s  = (state_q == ST_IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clock(clock),
        .reset(reset),
        .clear(clear_s),
        .tick (tick_s)
    );

    // Next state, then outputs decoded from the next state so they register in step.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    shift_d   = i_data_byte;
                    bit_idx_d = 3'd0;
                    state_d   = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (tick_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[bit_idx_d];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = even_parity(shift_d);
`endif
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset abandons any frame with the line high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign o_tx    = tx_q;
    assign o_ready = ready_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: accepted bytes are queued with their accept
// edge; a monitor compares the line against the expected frame waveform.
module tb_uart_tx;

    localparam int CPB = 100_000_000 / 115200;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam bit PAR   = 1'b1;
`else
    localparam int NBITS = 10;
    localparam bit PAR   = 1'b0;
`endif
    localparam int FRAME_CYC = NBITS * CPB;
    localparam int LIMIT     = 3 * FRAME_CYC;

    logic       clock;
    logic       reset;
    logic       i_data_valid;
    logic [7:0] i_data_byte;
    logic       o_ready;
    logic       o_tx;
    logic       o_busy;
    logic       o_done;

    uart_tx dut (
        .clock       (clock),
        .reset       (reset),
        .i_data_valid(i_data_valid),
        .i_data_byte (i_data_byte),
        .o_ready     (o_ready),
        .o_tx        (o_tx),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    typedef struct {
        logic [7:0] data;
        int         edge_n;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_acc = 0;
    int   last_acc = 0;
    int   frames_done = 0;
    int   done_cycles = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   d;
    int   ph;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected line level for frame bit position idx of byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (PAR && idx == 9) return ($countones(b) % 2) == 1;
        return 1'b1;
    endfunction

    // Reference model of acceptance: one frame at a time, free again after its end edge.
    initial forever begin
        @(posedge clock);
        cyc++;
        if (!reset && i_data_valid && sb_q.size() == 0) begin
            sb_q.push_back('{data: i_data_byte, edge_n: cyc});
            last_acc = cyc;
            n_acc++;
        end
    end

    // Monitor: compare the line and status against the head of the scoreboard.
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            if (o_done === 1'b1) done_cycles++;
            if (sb_q.size() > 0) begin
                d = cyc - sb_q[0].edge_n;
                if (d < FRAME_CYC) begin
                    ph = d % CPB;
                    if (ph == 0 || ph == CPB / 2 || ph == CPB - 1) begin
                        check("tx_bit", 32'(o_tx), 32'(frame_bit(sb_q[0].data, d / CPB)));
                        check("busy_in_frame", 32'(o_busy), 32'd1);
                        check("ready_in_frame", 32'(o_ready), 32'd0);
                        check("done_in_frame", 32'(o_done), 32'd0);
                    end
                end else begin
                    check("done_at_end", 32'(o_done), 32'd1);
                    check("busy_at_end", 32'(o_busy), 32'd0);
                    check("ready_at_end", 32'(o_ready), 32'd1);
                    check("tx_at_end", 32'(o_tx), 32'd1);
                    void'(sb_q.pop_front());
                    frames_done++;
                end
            end
        end
    end

    task automatic wait_accept(input int n0);
        int t = 0;
        while (n_acc == n0 && t < LIMIT) begin
            @(negedge clock);
            t++;
        end
        check("accepted", 32'(n_acc != n0), 32'd1);
    endtask

    task automatic send(input logic [7:0] b);
        int n0;
        @(negedge clock);
        n0 = n_acc;
        i_data_byte  = b;
        i_data_valid = 1'b1;
        wait_accept(n0);
        i_data_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (sb_q.size() > 0 && t < LIMIT) begin
            @(negedge clock);
            t++;
        end
        check("frame_finished", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check("idle_tx", 32'(o_tx), 32'd1);
            check("idle_ready", 32'(o_ready), 32'd1);
            check("idle_busy", 32'(o_busy), 32'd0);
            check("idle_done", 32'(o_done), 32'd0);
        end
    endtask

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: cycle=%0d required completion before limit", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        int a2;
        int n1;
        reset        = 1'b1;
        i_data_valid = 1'b0;
        i_data_byte  = 8'h00;
        repeat (3) @(negedge clock);
        check("rst_tx", 32'(o_tx), 32'd1);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        #2 reset = 1'b0;
        idle_check(3);

        send(8'h55);
        wait_idle();
        idle_check(3);

        // Reset in the middle of data bit 3.
        send(8'hA3);
        repeat (4 * CPB + CPB / 2) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("midrst_tx", 32'(o_tx), 32'd1);
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_ready", 32'(o_ready), 32'd1);
        check("midrst_done", 32'(o_done), 32'd0);
        sb_q.delete();
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        idle_check(3);
        send(8'h5A);
        wait_idle();
        idle_check(2);

        // Back-to-back with valid held high.
        @(negedge clock);
        n1 = n_acc;
        i_data_byte  = 8'h11;
        i_data_valid = 1'b1;
        wait_accept(n1);
        a1 = last_acc;
        n1 = n_acc;
        i_data_byte = 8'h22;
        wait_accept(n1);
        a2 = last_acc;
        i_data_valid = 1'b0;
        check("b2b_gap", 32'(a2 - a1), 32'(FRAME_CYC + 1));
        wait_idle();
        idle_check(2);

        // New byte and valid pulse mid-frame must be ignored.
        send(8'h07);
        repeat (3 * CPB) @(negedge clock);
        i_data_byte  = 8'($urandom);
        i_data_valid = 1'b1;
        repeat (5) @(negedge clock);
        i_data_valid = 1'b0;
        i_data_byte  = 8'($urandom);
        wait_idle();
        idle_check(4);

        send(8'h03);
        wait_idle();
        send(8'($urandom));
        wait_idle();
        idle_check(3);

        check("done_pulse_count", 32'(done_cycles), 32'(frames_done));
        check("frames_completed", 32'(frames_done), 32'd7);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter that serialises one byte per request onto the TX line: 8N1 by default, with an optional even-parity bit. It sits beside `uart_rx` in the PL↔PS UART path and uses the same bit timing. A producer hands it bytes over a valid/ready handshake. Its line output is the mirror image of what `uart_rx` samples.

## Interface
- `baud`, 115200: line rate, in bits per second.
- `CLK_FREQ`, 100_000_000: `clock` frequency in Hz.
- `clock`, in, 1: single system clock; all logic is on the rising edge.
- `reset`, in, 1: reset is asynchronous and active-high.
- `i_data_valid`, in, 1: a byte is offered on `i_data_byte`.
- `i_data_byte`, in, 8: the byte to send; it is sampled only at the accept edge.
- `o_ready`, out, 1: the block can accept a byte; high only in IDLE.
- `o_tx`, out, 1: serial line, registered; the line idles high.
- `o_busy`, out, 1: a frame is in progress, from START through STOP.
- `o_done`, out, 1: one-cycle pulse at the end of the stop bit.

## Operation
- CLKS_PER_BIT = CLK_FREQ/baud, using integer division; the default is 868.
- CLKS_PER_BIT outside 2..65535 is a fatal elaboration error.
- Bit counter is 16 bits wide and runs 0..CLKS_PER_BIT-1. The bit index is 3 bits.
- An accept happens on a rising edge where `i_data_valid` && `o_ready` are both high.
  - On that edge `i_data_byte` is copied into the shift register.
  - The same edge moves the FSM to START.
- `i_data_valid` while not ready is ignored. The byte is neither queued nor dropped with an error; the producer holds it until ready.
- States and transitions:
  - IDLE: `o_tx`=1, `o_ready`=1. On accept, go to START.
  - START: `o_tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `o_tx`=shift[bit_index], LSB first, CLKS_PER_BIT cycles per bit. After bit 7, go to PARITY (macro set) or STOP.
  - PARITY: `o_tx`=^byte (even parity) for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: `o_tx`=1 for CLKS_PER_BIT cycles, then go to IDLE and pulse `o_done`.
  - Illegal state: go to IDLE.
- Reset values: `o_tx`=1, `o_ready`=1, `o_busy`=0, `o_done`=0, FSM in IDLE, counters 0.
- Reset mid-frame: the frame is abandoned immediately and asynchronously, with `o_tx` forced to 1. No `o_done` pulse is produced.

## Timing
- Let E0 be the accept edge. `o_tx` falls right after E0 and `o_busy` rises right after E0.
- Data bit k drives `o_tx` from edge E0+(1+k)·CLKS_PER_BIT.
- Stop bit starts at E0+9·CLKS_PER_BIT, or at E0+10·CLKS_PER_BIT with parity.
- End of frame, at F = E0+10·CLKS_PER_BIT (11· with parity):
  - `o_done`=1 for exactly one cycle.
  - `o_busy`=0 and `o_ready`=1.
- Back-to-back: with valid held high, the next accept happens at edge F+1. The stop/idle high time between frames is therefore CLKS_PER_BIT+1 cycles.

## Configuration
- `UART_TX_PARITY_EN`
  - Defined: the PARITY state is compiled in, giving an 11-bit frame (start, 8 data, even parity, stop).
  - Undefined: PARITY logic is absent, giving an 8N1 10-bit frame.
  - Ports are identical in both builds.

## Structure
- Package `uart_pkg` holds:
  - the state encodings, shared with `uart_rx`: IDLE=0, START=1, DATA=2, STOP=3, PARITY=4, in 3 bits;
  - the function `clks_per_bit(freq, baud)`.
- One sub-module, `uart_baud_tick`. It takes `clock`, `reset`, `clear` and CLKS_PER_BIT, and gives a one-cycle `tick` at the end of each bit period. The FSM and shift register stay in `uart_tx`.

## Test plan
- Default build, send 0x55: `o_tx` reads 0,1,0,1,0,1,0,1,0,1, each bit 868 cycles. `o_done` is seen exactly 8680 cycles after accept.
- Send 0xA3 looped back into `uart_rx`: `o_data_avail` pulses with `o_data_byte`=0xA3.
- Parity build, send 0x07: the parity bit is 1 and `o_done` comes at 9548 cycles. Send 0x03: the parity bit is 0.
- `i_data_valid` held high, bytes 0x11 then 0x22: the second accept is at F+1. `o_ready` is low for the whole first frame, and both bytes arrive intact.
- Change `i_data_byte` and pulse valid mid-frame: the transmitted byte is unchanged, there is no extra frame, and `o_ready` stays 0.
- Assert `reset` during bit 3: `o_tx`=1 immediately, with no `o_done`. After release, 0x5A is sent correctly.
